inst_loader: RTL and testbench
==============================

# inst_loader

Byte-stream loader that fills the instruction memory before execution. It takes bytes from the UART receiver and assembles them little-endian into 32-bit instruction words. Each word goes out as a one-cycle write strobe, with address and data, on the instruction memory's write port. Loading stops after the HALT word or when the memory is full; it sits between the UART RX and the instruction memory, controlled by the debug unit.

## Interface
- NB_DATA, 32, instruction word width
- NBYTE, 8, byte width of the UART stream
- N_ELEMENTS, 128, instruction memory depth in words
- NB_ADDR, 7, word address width (log2 N_ELEMENTS)
- HALT_WORD, 32'hFFFFFFFF, terminating instruction; it is itself written to memory

- clock_i  in  1  single clock, all logic on rising edge
- reset_i  in  1  asynchronous, active-high reset
- start_i  in  1  one-cycle pulse, begin a new load at address 0
- rx_data_i  in  NBYTE  received byte, valid when rx_done_i=1
- rx_done_i  in  1  one-cycle strobe, one byte available
- en_write_o  out  1  instruction memory write enable, one cycle per word
- addr_o  out  NB_ADDR  write word address
- data_o  out  NB_DATA  write word
- busy_o  out  1  high in RECV/WRITE (and CHECK)
- load_done_o  out  1  held high in DONE
- overflow_o  out  1  memory filled without HALT_WORD; valid with load_done_o
- checksum_err_o  out  1  present only with INST_LOADER_CHECKSUM_EN

## Operation
- States: IDLE, RECV, WRITE, DONE (plus CHECK under macro).
- IDLE: wait for start_i, then go to RECV and clear the word address, byte counter, assembly register, overflow_o and load_done_o.
- RECV: each rx_done_i shifts rx_data_i into the assembly register. Byte k (k=0..3) lands in bits [8k+7:8k]. The byte counter runs 0..3 and wraps.
- When the 4th byte is accepted, load data_o from the completed assembly, set addr_o to the current word address, and go to WRITE.
- WRITE (exactly one cycle): en_write_o=1. The next state is chosen in this order:
  - Word equals HALT_WORD: go to DONE, or to CHECK under the macro.
  - Else address = N_ELEMENTS-1: set overflow_o=1 and go to DONE.
  - Else increment the address and return to RECV.
- rx_done_i during WRITE counts as byte 0 of the next word when returning to RECV. Under the macro's CHECK path it is the checksum byte. Otherwise it is dropped.
- DONE: load_done_o=1, busy_o=0, bytes ignored. start_i restarts the load exactly as from IDLE.
- start_i in RECV/WRITE/CHECK is ignored. A partial word is never written.
- Reset at any point, including mid-word or during WRITE, forces IDLE. All outputs, the address, the counter and the assembly register go to 0. No write strobe is produced.

## Timing
- Reset values: en_write_o=0, addr_o=0, data_o=0, busy_o=0, load_done_o=0, overflow_o=0, checksum_err_o=0.
- All outputs are registered.
- en_write_o rises the cycle after the rx_done_i of the 4th byte and lasts 1 cycle. addr_o and data_o are stable in that cycle and hold until the next word.
- load_done_o rises the cycle after the HALT WRITE cycle, or after the overflow WRITE cycle.
- Minimum spacing between rx_done_i strobes is 1 cycle. Back-to-back bytes are never lost.

## Configuration
- INST_LOADER_CHECKSUM_EN defined:
  - A running XOR of every accepted byte is kept, including the HALT word's bytes; it is cleared on start.
  - After the HALT WRITE the block enters CHECK and waits for one byte.
  - On that byte: checksum_err_o = (byte != running XOR), then DONE. load_done_o rises the cycle after that byte.
  - The overflow path skips CHECK.
- Undefined: no CHECK state, no XOR register, no checksum_err_o port. HALT goes directly to DONE.

## Test plan
- Reset, start, then bytes 78 56 34 12 → one en_write_o with addr_o=0, data_o=32'h12345678, then RECV with address 1.
- Start, then words 0x20010005, 0xFFFFFFFF sent back-to-back with 1-cycle byte spacing → writes at addr 0 and 1; load_done_o=1 and overflow_o=0 the cycle after the second strobe.
- 128 non-HALT words → 128 strobes at addr 0..127, then load_done_o=1 and overflow_o=1. A 129th word produces no strobe.
- Assert reset_i after 2 bytes of word 3 → all outputs 0 immediately. After start, the next 4 bytes write at addr 0.
- Checksum build, HALT-only stream FF FF FF FF, then checksum byte 00 → checksum_err_o=0. Repeated with checksum byte 01 → checksum_err_o=1; load_done_o=1 in both cases.
- In DONE, pulse start_i and send 4 bytes → overflow_o and load_done_o clear, write at addr 0.

Source files
------------

// File: rtl/inst_loader.sv
// Byte-stream instruction loader: assembles UART bytes little-endian into words and
// writes them to instruction memory. Optional checksum stage: INST_LOADER_CHECKSUM_EN.
module inst_loader #(
  parameter int                  NB_DATA    = 32,
  parameter int                  NBYTE      = 8,
  parameter int                  N_ELEMENTS = 128,
  parameter int                  NB_ADDR    = 7,
  parameter logic [NB_DATA-1:0]  HALT_WORD  = 32'hFFFFFFFF
) (
  input  logic               clock_i,
  input  logic               reset_i,
  input  logic               start_i,
  input  logic [NBYTE-1:0]   rx_data_i,
  input  logic               rx_done_i,
  output logic               en_write_o,
  output logic [NB_ADDR-1:0] addr_o,
  output logic [NB_DATA-1:0] data_o,
  output logic               busy_o,
  output logic               load_done_o,
  output logic               overflow_o
`ifdef INST_LOADER_CHECKSUM_EN
  ,
  output logic               checksum_err_o
`endif
);

  localparam int BYTES  = NB_DATA / NBYTE;
  localparam int NB_CNT = (BYTES > 1) ? $clog2(BYTES) : 1;
  localparam logic [NB_CNT-1:0]  LAST_BYTE = NB_CNT'(BYTES - 1);
  localparam logic [NB_ADDR-1:0] LAST_ADDR = NB_ADDR'(N_ELEMENTS - 1);

  typedef enum logic [2:0] {
    IDLE,
    RECV,
    WRITE,
    DONE
`ifdef INST_LOADER_CHECKSUM_EN
    ,
    CHECK
`endif
  } state_t;

  state_t              state, state_next;
  logic [NB_ADDR-1:0]  word_addr, word_addr_next;
  logic [NB_CNT-1:0]   byte_cnt, byte_cnt_next;
  logic [NB_DATA-1:0]  assembly, assembly_next;
  logic [NB_ADDR-1:0]  addr_next;
  logic [NB_DATA-1:0]  data_next;
  logic                en_write_next;
  logic                busy_next;
  logic                load_done_next;
  logic                overflow_next;
  logic                accept;
`ifdef INST_LOADER_CHECKSUM_EN
  logic [NBYTE-1:0]    xor_acc, xor_acc_next;
  logic                checksum_err_next;
`endif

  // NOTE: every variable gets a default at the top of the block so no path can
  // leave it unassigned, which would otherwise infer a latch.
  always_comb begin
    state_next     = state;
    word_addr_next = word_addr;
    byte_cnt_next  = byte_cnt;
    assembly_next  = assembly;
    addr_next      = addr_o;
    data_next      = data_o;
    en_write_next  = 1'b0;
    load_done_next = load_done_o;
    overflow_next  = overflow_o;
    accept         = 1'b0;
`ifdef INST_LOADER_CHECKSUM_EN
    xor_acc_next      = xor_acc;
    checksum_err_next = checksum_err_o;
`endif

    case (state)
      IDLE, DONE: begin
        if (start_i) begin
          state_next     = RECV;
          word_addr_next = '0;
          byte_cnt_next  = '0;
          assembly_next  = '0;
          load_done_next = 1'b0;
          overflow_next  = 1'b0;
`ifdef INST_LOADER_CHECKSUM_EN
          xor_acc_next      = '0;
          checksum_err_next = 1'b0;
`endif
        end
      end
      RECV: accept = rx_done_i;
      WRITE: begin
        if (data_o == HALT_WORD) begin
`ifdef INST_LOADER_CHECKSUM_EN
          // A byte arriving in the HALT write cycle is already the checksum byte.
          if (rx_done_i) begin
            checksum_err_next = (rx_data_i != xor_acc);
            load_done_next    = 1'b1;
            state_next        = DONE;
          end else begin
            state_next = CHECK;
          end
`else
          load_done_next = 1'b1;
          state_next     = DONE;
`endif
        end else if (word_addr == LAST_ADDR) begin
          overflow_next  = 1'b1;
          load_done_next = 1'b1;
          state_next     = DONE;
        end else begin
          word_addr_next = word_addr + 1'b1;
          state_next     = RECV;
          accept         = rx_done_i;
        end
      end
`ifdef INST_LOADER_CHECKSUM_EN
      CHECK: begin
        if (rx_done_i) begin
          checksum_err_next = (rx_data_i != xor_acc);
          load_done_next    = 1'b1;
          state_next        = DONE;
        end
      end
`endif
      default: state_next = IDLE;
    endcase

    if (accept) begin
      assembly_next[byte_cnt*NBYTE +: NBYTE] = rx_data_i;
      byte_cnt_next = byte_cnt + 1'b1;
`ifdef INST_LOADER_CHECKSUM_EN
      xor_acc_next = xor_acc ^ rx_data_i;
`endif
      if (byte_cnt == LAST_BYTE) begin
        data_next     = assembly_next;
        addr_next     = word_addr_next;
        en_write_next = 1'b1;
        state_next    = WRITE;
      end
    end

    busy_next = (state_next == RECV) || (state_next == WRITE);
`ifdef INST_LOADER_CHECKSUM_EN
    busy_next = busy_next || (state_next == CHECK);
`endif
  end

  // NOTE: state registers use non-blocking assignments so every flop samples the
  // pre-edge values, independent of statement order.
  always_ff @(posedge clock_i or posedge reset_i) begin
    if (reset_i) begin
      state       <= IDLE;
      word_addr   <= '0;
      byte_cnt    <= '0;
      assembly    <= '0;
      en_write_o  <= 1'b0;
      addr_o      <= '0;
      data_o      <= '0;
      busy_o      <= 1'b0;
      load_done_o <= 1'b0;
      overflow_o  <= 1'b0;
    end else begin
      state       <= state_next;
      word_addr   <= word_addr_next;
      byte_cnt    <= byte_cnt_next;
      assembly    <= assembly_next;
      en_write_o  <= en_write_next;
      addr_o      <= addr_next;
      data_o      <= data_next;
      busy_o      <= busy_next;
      load_done_o <= load_done_next;
      overflow_o  <= overflow_next;
    end
  end

`ifdef INST_LOADER_CHECKSUM_EN
  always_ff @(posedge clock_i or posedge reset_i) begin
    if (reset_i) begin
      xor_acc        <= '0;
      checksum_err_o <= 1'b0;
    end else begin
      xor_acc        <= xor_acc_next;
      checksum_err_o <= checksum_err_next;
    end
  end
`endif

endmodule

// File: tb/tb_inst_loader.sv
// Self-checking bench for inst_loader: vector table, hand-written corner sequences
// and randomized streams checked against a word-list reference model.
module tb_inst_loader;

  localparam int NB_DATA    = 32;
  localparam int NBYTE      = 8;
  localparam int N_ELEMENTS = 128;
  localparam int NB_ADDR    = 7;
  localparam logic [NB_DATA-1:0] HALT = 32'hFFFFFFFF;

  logic               clock   = 1'b0;
  logic               reset   = 1'b1;
  logic               start   = 1'b0;
  logic               rx_done = 1'b0;
  logic [NBYTE-1:0]   rx_data = '0;
  logic               en_write;
  logic [NB_ADDR-1:0] addr;
  logic [NB_DATA-1:0] data;
  logic               busy;
  logic               load_done;
  logic               overflow;
`ifdef INST_LOADER_CHECKSUM_EN
  logic               checksum_err;
`endif

  inst_loader dut (
    .clock_i     (clock),
    .reset_i     (reset),
    .start_i     (start),
    .rx_data_i   (rx_data),
    .rx_done_i   (rx_done),
    .en_write_o  (en_write),
    .addr_o      (addr),
    .data_o      (data),
    .busy_o      (busy),
    .load_done_o (load_done),
    .overflow_o  (overflow)
`ifdef INST_LOADER_CHECKSUM_EN
    ,
    .checksum_err_o (checksum_err)
`endif
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [NB_ADDR-1:0] addr;
    logic [NB_DATA-1:0] data;
  } wr_t;

  typedef struct {
    logic [7:0]         b0, b1, b2, b3;
    logic [NB_ADDR-1:0] exp_addr;
    logic [NB_DATA-1:0] exp_data;
    logic               exp_done;
  } vec_t;

  int         n_cmp = 0;
  int         n_err = 0;
  logic [7:0] tb_xor = '0;
  wr_t        wq[$];
  wr_t        exp_q[$];

  // Write-port monitor, sampled mid-cycle.
  always @(negedge clock) begin
    if (en_write) wq.push_back('{addr: addr, data: data});
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap);
    repeat (gap) tick();
    rx_data = b;
    rx_done = 1'b1;
    tb_xor  = tb_xor ^ b;
    tick();
    rx_done = 1'b0;
  endtask

  task automatic send_word(input logic [31:0] w, input int max_gap);
    for (int k = 0; k < 4; k++) send_byte(w[8*k +: 8], $urandom_range(0, max_gap));
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start  = 1'b0;
    tb_xor = '0;
    wq.delete();
  endtask

  // Called in the HALT write cycle; leaves the bench one cycle into DONE.
  task automatic halt_tail();
`ifdef INST_LOADER_CHECKSUM_EN
    send_byte(tb_xor, 0);
`else
    tick();
`endif
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_en_write"},  en_write,  0);
    check({tag, "_addr"},      addr,      0);
    check({tag, "_data"},      data,      0);
    check({tag, "_busy"},      busy,      0);
    check({tag, "_load_done"}, load_done, 0);
    check({tag, "_overflow"},  overflow,  0);
`ifdef INST_LOADER_CHECKSUM_EN
    check({tag, "_cksum_err"}, checksum_err, 0);
`endif
  endtask

  task automatic compare_queues(input string tag);
    int n;
    check({tag, "_count"}, wq.size(), exp_q.size());
    n = (wq.size() < exp_q.size()) ? wq.size() : exp_q.size();
    for (int i = 0; i < n; i++) begin
      check($sformatf("%s_addr%0d", tag, i), wq[i].addr, exp_q[i].addr);
      check($sformatf("%s_data%0d", tag, i), wq[i].data, exp_q[i].data);
    end
  endtask

  function automatic logic [31:0] rand_word();
    logic [31:0] w;
    w = $urandom;
    if ($urandom_range(0, 3) == 0) w = w | 32'hFFFFFF00;
    if (w == HALT) w = 32'hFFFFFFFE;
    return w;
  endfunction

  initial begin
    vec_t        vecs[6];
    logic [31:0] words[$];
    int          h;

    vecs[0] = '{8'h78, 8'h56, 8'h34, 8'h12, 7'd0, 32'h12345678, 1'b0};
    vecs[1] = '{8'h05, 8'h00, 8'h01, 8'h20, 7'd1, 32'h20010005, 1'b0};
    vecs[2] = '{8'h00, 8'h00, 8'h00, 8'h00, 7'd2, 32'h00000000, 1'b0};
    vecs[3] = '{8'hFE, 8'hFF, 8'hFF, 8'hFF, 7'd3, 32'hFFFFFFFE, 1'b0};
    vecs[4] = '{8'hFF, 8'hFF, 8'hFF, 8'h7F, 7'd4, 32'h7FFFFFFF, 1'b0};
    vecs[5] = '{8'hFF, 8'hFF, 8'hFF, 8'hFF, 7'd5, 32'hFFFFFFFF, 1'b1};

    // Reset state
    #2;
    check_all_zero("reset");
    repeat (2) tick();
    reset = 1'b0;
    tick();
    check("idle_busy", busy, 0);

    // Vector table, bytes back-to-back including the write cycle
    pulse_start();
    check("tbl_busy", busy, 1);
    for (int i = 0; i < 6; i++) begin
      send_byte(vecs[i].b0, 0);
      send_byte(vecs[i].b1, 0);
      send_byte(vecs[i].b2, 0);
      send_byte(vecs[i].b3, 0);
      check($sformatf("tbl%0d_en_write", i), en_write, 1);
      check($sformatf("tbl%0d_addr", i), addr, vecs[i].exp_addr);
      check($sformatf("tbl%0d_data", i), data, vecs[i].exp_data);
      if (vecs[i].exp_done) begin
        halt_tail();
        check($sformatf("tbl%0d_load_done", i), load_done, 1);
        check($sformatf("tbl%0d_overflow", i), overflow, 0);
        check($sformatf("tbl%0d_busy", i), busy, 0);
        check($sformatf("tbl%0d_en_write_low", i), en_write, 0);
      end
    end
    check("tbl_strobe_count", wq.size(), 6);

    // Randomized HALT-terminated streams against the word-list model
    for (int run = 0; run < 4; run++) begin
      h = $urandom_range(0, 20);
      words.delete();
      exp_q.delete();
      for (int j = 0; j < h; j++) words.push_back(rand_word());
      words.push_back(HALT);
      for (int j = 0; j < words.size(); j++) exp_q.push_back('{addr: NB_ADDR'(j), data: words[j]});
      pulse_start();
      foreach (words[j]) send_word(words[j], 2);
      halt_tail();
      check($sformatf("rnd%0d_load_done", run), load_done, 1);
      check($sformatf("rnd%0d_overflow", run), overflow, 0);
      compare_queues($sformatf("rnd%0d", run));
    end

    // Fill the whole memory without HALT
    exp_q.delete();
    pulse_start();
    for (int j = 0; j < N_ELEMENTS; j++) begin
      logic [31:0] w;
      w = rand_word();
      exp_q.push_back('{addr: NB_ADDR'(j), data: w});
      send_word(w, 1);
    end
    tick();
    check("ovf_load_done", load_done, 1);
    check("ovf_overflow", overflow, 1);
    check("ovf_busy", busy, 0);
    compare_queues("ovf");
    wq.delete();
    send_word(32'h11223344, 0);
    repeat (3) tick();
    check("ovf_extra_no_strobe", wq.size(), 0);
    check("ovf_still_done", load_done, 1);

    // Restart from DONE
    pulse_start();
    check("restart_load_done", load_done, 0);
    check("restart_overflow", overflow, 0);
    send_word(32'hCAFEBABE, 0);
    check("restart_en_write", en_write, 1);
    check("restart_addr", addr, 0);
    check("restart_data", data, 32'hCAFEBABE);

    // Reset in the middle of a word
    pulse_start();
    for (int j = 0; j < 3; j++) send_word(32'h01020304 + j, 0);
    send_byte(8'hAA, 0);
    send_byte(8'hBB, 0);
    reset = 1'b1;
    #1;
    check_all_zero("midreset");
    wq.delete();
    tick();
    reset = 1'b0;
    repeat (3) tick();
    check("midreset_no_strobe", wq.size(), 0);
    check("midreset_idle_busy", busy, 0);
    pulse_start();
    send_word(32'hA5A55A5A, 0);
    check("postreset_en_write", en_write, 1);
    check("postreset_addr", addr, 0);
    check("postreset_data", data, 32'hA5A55A5A);

`ifdef INST_LOADER_CHECKSUM_EN
    // HALT-only stream: XOR of FF FF FF FF is 00
    pulse_start();
    send_word(HALT, 0);
    tick();
    send_byte(8'h00, 0);
    check("cksum_ok_err", checksum_err, 0);
    check("cksum_ok_done", load_done, 1);
    pulse_start();
    send_word(HALT, 0);
    tick();
    send_byte(8'h01, 0);
    check("cksum_bad_err", checksum_err, 1);
    check("cksum_bad_done", load_done, 1);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
